// File: rtl/walk_lamp_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : walk_lamp_driver_pkg
//  Description : Shared state encoding, phase counter sizing and request
//                helpers for the crosswalk walk-lamp driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package walk_lamp_driver_pkg;

  // State encoding shared by the FSM and anyone decoding it downstream.
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t RED    = 2'd0;
  localparam state_t GREEN  = 2'd1;
  localparam state_t ORANGE = 2'd2;
  localparam state_t FAULT  = 2'd3;

  // Phase duration counter sizing; it saturates rather than wrapping.
  localparam int              PHASE_W   = 8;
  localparam logic [PHASE_W-1:0] PHASE_MAX = 8'd255;

  // Width of the invalid-run and blink counters (parameters are 1..255).
  localparam int CNT_W = 8;

  // Pedestrian request vector as delivered by the control unit.
  typedef struct packed {
    logic green;
    logic orange;
    logic red;
  } ped_req_t;

  // A request vector is meaningful only when exactly one line is high.
  function automatic logic req_valid(input ped_req_t req);
    logic [1:0] ones;
    ones = {1'b0, req.green} + {1'b0, req.orange} + {1'b0, req.red};
    return (ones == 2'd1);
  endfunction

  // Map a valid request vector onto the state it asks for.
  function automatic state_t req_state(input ped_req_t req);
    state_t st;
    st = RED;
    if (req.green) begin
      st = GREEN;
    end else if (req.orange) begin
      st = ORANGE;
    end
    return st;
  endfunction

endpackage : walk_lamp_driver_pkg
`default_nettype wire

// File: rtl/walk_lamp_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : walk_lamp_driver_if
//  Description : Pedestrian request inputs and lamp/status outputs of the
//                walk-lamp driver, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface walk_lamp_driver_if;
  import walk_lamp_driver_pkg::*;

  // Requests from the crosswalk control unit.
  logic green_walk;
  logic orange_walk;
  logic red_hand;

  // Lamp drives and status back from the driver.
  logic               lamp_green;
  logic               lamp_orange;
  logic               lamp_red;
  logic               fault;
  logic [PHASE_W-1:0] phase_cycles;

  // Control-unit side: issues requests, observes lamps.
  modport master (
    output green_walk,
    output orange_walk,
    output red_hand,
    input  lamp_green,
    input  lamp_orange,
    input  lamp_red,
    input  fault,
    input  phase_cycles
  );

  // Driver side: consumes requests, drives lamps.
  modport slave (
    input  green_walk,
    input  orange_walk,
    input  red_hand,
    output lamp_green,
    output lamp_orange,
    output lamp_red,
    output fault,
    output phase_cycles
  );

endinterface : walk_lamp_driver_if
`default_nettype wire

// File: rtl/walk_lamp_driver_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : blink_timer
//  Description : Orange-lamp blink generator. Level starts at 1 on restart,
//                toggles every BLINK_HALF enabled cycles and is forced low
//                (counter parked at 0) whenever neither input is active.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_timer
  import walk_lamp_driver_pkg::*;
#(
  parameter int BLINK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic level
);

  // Terminal count of one half-period (counter runs 0..BLINK_HALF-1).
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] count;
  logic             level_q;

  // Half-period counter and blink level; level low outside the orange phase
  // so it can drive the lamp directly as a register output.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      level_q <= 1'b0;
    end else if (restart) begin
      count   <= '0;
      level_q <= 1'b1;
    end else if (enable) begin
      if (count == HALF_LAST) begin
        count   <= '0;
        level_q <= ~level_q;
      end else begin
        count   <= count + CNT_W'(1);
      end
    end else begin
      count   <= '0;
      level_q <= 1'b0;
    end
  end

  assign level = level_q;

endmodule : blink_timer
`default_nettype wire

// File: rtl/walk_lamp_driver.sv
`default_nettype none
// ============================================================================
//  Module      : walk_lamp_driver
//  Description : Drives the physical walk lamps from the pedestrian request
//                lines, blinks orange during clearance, reports phase length
//                and latches a fail-safe fault on persistent bad requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module walk_lamp_driver
  import walk_lamp_driver_pkg::*;
#(
  parameter int BLINK_HALF  = 2,
  parameter int FAULT_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  walk_lamp_driver_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_LIMIT);

  ped_req_t           req;
  logic               req_ok;
  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   invalid_cnt;
  logic [CNT_W-1:0]   invalid_next;
  logic [CNT_W-1:0]   invalid_inc;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_next;
  logic               green_d;
  logic               red_d;
  logic               fault_d;
  logic               green_q;
  logic               red_q;
  logic               fault_q;
  logic               blink_enable;
  logic               blink_restart;
  logic               blink_level;

  assign req.green  = bus.green_walk;
  assign req.orange = bus.orange_walk;
  assign req.red    = bus.red_hand;
  assign req_ok     = req_valid(req);
  assign invalid_inc = invalid_cnt + CNT_W'(1);

  // State register and invalid-run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RED;
      invalid_cnt <= '0;
    end else begin
      state       <= next_state;
      invalid_cnt <= invalid_next;
    end
  end

  // Next-state logic: follow valid requests, hold on bad ones until the
  // run of bad vectors reaches the limit; FAULT never exits without reset.
  always_comb begin
    next_state   = state;
    invalid_next = invalid_cnt;
    if (state != FAULT) begin
      if (req_ok) begin
        next_state   = req_state(req);
        invalid_next = '0;
      end else begin
        invalid_next = invalid_inc;
        if (invalid_inc == LIMIT) begin
          next_state = FAULT;
        end
      end
    end
  end

  // Output decode from the upcoming state so lamps are registered with the
  // one-cycle latency from input sample to lamp.
  always_comb begin
    green_d       = 1'b0;
    red_d         = 1'b0;
    fault_d       = 1'b0;
    blink_enable  = 1'b0;
    blink_restart = 1'b0;
    case (next_state)
      RED:    red_d = 1'b1;
      GREEN:  green_d = 1'b1;
      ORANGE: begin
        blink_restart = (state != ORANGE);
        blink_enable  = (state == ORANGE);
      end
      default: begin
        red_d   = 1'b1;
        fault_d = 1'b1;
      end
    endcase
  end

  // Phase length: restart on any state change, otherwise count and saturate.
  always_comb begin
    phase_next = phase_q;
    if (next_state != state) begin
      phase_next = '0;
    end else if (phase_q != PHASE_MAX) begin
      phase_next = phase_q + PHASE_W'(1);
    end
  end

  // Lamp, fault and phase output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      green_q <= 1'b0;
      red_q   <= 1'b1;
      fault_q <= 1'b0;
      phase_q <= '0;
    end else begin
      green_q <= green_d;
      red_q   <= red_d;
      fault_q <= fault_d;
      phase_q <= phase_next;
    end
  end

  blink_timer #(
    .BLINK_HALF (BLINK_HALF)
  ) blink_timer_inst (
    .clk     (clk),
    .reset   (reset),
    .enable  (blink_enable),
    .restart (blink_restart),
    .level   (blink_level)
  );

  assign bus.lamp_green   = green_q;
  assign bus.lamp_orange  = blink_level;
  assign bus.lamp_red     = red_q;
  assign bus.fault        = fault_q;
  assign bus.phase_cycles = phase_q;

endmodule : walk_lamp_driver
`default_nettype wire

// File: tb/tb_walk_lamp_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_walk_lamp_driver
//  Description : Directed scoreboard bench for walk_lamp_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_walk_lamp_driver;

  typedef struct {
    int         scen;
    int         idx;
    logic       lg;
    logic       lo;
    logic       lr;
    logic       f;
    logic [7:0] pc;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step_no;
  exp_t exp_q[$];

  walk_lamp_driver_if wl_if ();

  walk_lamp_driver #(
    .BLINK_HALF  (2),
    .FAULT_LIMIT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string scen_name(input int s);
    case (s)
      0: return "reset";
      1: return "red_phase";
      2: return "green_phase";
      3: return "orange_blink";
      4: return "glitch_hold";
      5: return "fault_entry";
      6: return "fault_latched";
      7: return "reset_wins";
      8: return "reset_mid_orange";
      9: return "orange_reentry";
      10: return "saturation";
      default: return "other";
    endcase
  endfunction

  // Drive one input vector and queue the outputs expected after the next edge.
  task automatic step(input logic rs, input logic g, input logic o, input logic r,
                      input logic lg, input logic lo, input logic lr, input logic f,
                      input int pc, input int scen);
    exp_t e;
    @(negedge clk);
    reset             = rs;
    wl_if.green_walk  = g;
    wl_if.orange_walk = o;
    wl_if.red_hand    = r;
    e.scen = scen;
    e.idx  = step_no;
    e.lg   = lg;
    e.lo   = lo;
    e.lr   = lr;
    e.f    = f;
    e.pc   = 8'(pc);
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: after each edge, compare the DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wl_if.lamp_green !== e.lg || wl_if.lamp_orange !== e.lo ||
            wl_if.lamp_red !== e.lr || wl_if.fault !== e.f ||
            wl_if.phase_cycles !== e.pc) begin
          errors++;
          $display("FAIL %s step %0d: got g=%b o=%b r=%b f=%b pc=%0d, expected g=%b o=%b r=%b f=%b pc=%0d",
                   scen_name(e.scen), e.idx, wl_if.lamp_green, wl_if.lamp_orange,
                   wl_if.lamp_red, wl_if.fault, wl_if.phase_cycles,
                   e.lg, e.lo, e.lr, e.f, e.pc);
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    reset   = 1'b1;
    wl_if.green_walk  = 1'b0;
    wl_if.orange_walk = 1'b0;
    wl_if.red_hand    = 1'b0;

    // Reset held 2 cycles with random request lines.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1, 0, 0, 0);
    end

    // red_hand 3 cycles: stays RED, phase keeps counting from reset.
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, 0, 0, 1, 0, i, 1);
    // green_walk 5 cycles: phase 0..4.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 0, 0, 0, i, 2);
    // orange_walk 4 cycles: blink 1,1,0,0.
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 1, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2, 3);
    step(0, 0, 1, 0, 0, 0, 0, 0, 3, 3);

    // Back to GREEN, then a 2-cycle all-low glitch that must be ridden out.
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 4);
    step(0, 1, 0, 0, 1, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 0, 0, 0, 2, 4);
    step(0, 0, 0, 0, 1, 0, 0, 0, 3, 4);
    step(0, 1, 0, 0, 1, 0, 0, 0, 4, 4);

    // green+red together: held twice, third sample enters FAULT.
    step(0, 1, 0, 1, 1, 0, 0, 0, 5, 5);
    step(0, 1, 0, 1, 1, 0, 0, 0, 6, 5);
    step(0, 1, 0, 1, 0, 0, 1, 1, 0, 5);
    // Valid green is ignored; fault stays, phase counts on.
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 0, 0, 1, 1, i, 6);

    // Reset with a valid green on the same cycle: reset wins.
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 7);
    // Orange 3 cycles then reset while lamp_orange is low.
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 8);
    step(0, 0, 1, 0, 0, 1, 0, 0, 1, 8);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2, 8);
    step(1, 0, 1, 0, 0, 0, 1, 0, 0, 8);
    // Re-entering ORANGE restarts the blink at 1.
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 9);
    step(0, 0, 1, 0, 0, 1, 0, 0, 1, 9);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2, 9);

    // red_hand 300 cycles: phase climbs to 255 and sticks.
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 1, 0, 0, 1, 0, (i > 255) ? 255 : i, 10);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_walk_lamp_driver
`default_nettype wire
